// File: rtl/lfsr_crypt_engine.sv
// Byte-stream cipher keyed by a 7-bit Fibonacci LFSR. Encrypt uses supplied taps/seed;
// decrypt recovers seed and tap pattern from a known padding preamble, then deciphers.
module lfsr_crypt_engine #(
   parameter int                         DATA_W     = 8,
   parameter int                         LFSR_W     = 7,
   parameter int                         NUM_PTRN   = 9,
   parameter logic [NUM_PTRN*LFSR_W-1:0] PTRN_TABLE = {7'h60, 7'h48, 7'h78, 7'h72, 7'h6A,
                                                      7'h69, 7'h5C, 7'h7E, 7'h7B},
   parameter logic [DATA_W-1:0]          PAD_CHAR   = 8'h20,
   parameter int                         TRAIN_LEN  = 8,
   parameter int                         LEN_W      = 7,
   localparam int                        IDX_W      = (NUM_PTRN > 1) ? $clog2(NUM_PTRN) : 1
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   input  logic              Mode,
   input  logic [LFSR_W-1:0] Taps_in,
   input  logic [LFSR_W-1:0] Seed_in,
   input  logic [LEN_W-1:0]  Len,
   input  logic [DATA_W-1:0] In_data,
   input  logic              In_valid,
   output logic              In_ready,
   output logic [DATA_W-1:0] Out_data,
   output logic              Out_valid,
   input  logic              Out_ready,
   output logic              Busy,
   output logic              Ack,
   output logic              Parity_err,
   output logic              Ptrn_found,
   output logic [IDX_W-1:0]  Ptrn_idx,
   output logic              Key_err,
   output logic [2:0]        dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SEED  = 3'd1,
      S_TRAIN = 3'd2,
      S_RUN   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic                mode_q, mode_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [LEN_W-1:0]    cnt_q, cnt_d;
   logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
   logic [LFSR_W-1:0]   taps_q, taps_d;
   logic [NUM_PTRN-1:0] mask_q, mask_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic                out_valid_q, out_valid_d;
   logic                busy_q, busy_d;
   logic                ack_q, ack_d;
   logic                parity_err_q, parity_err_d;
   logic                ptrn_found_q, ptrn_found_d;
   logic [IDX_W-1:0]    ptrn_idx_q, ptrn_idx_d;
   logic                key_err_q, key_err_d;

   logic                active, out_free, accept, train_last;
   logic [LFSR_W-1:0]   obs, sel_taps;
   logic [DATA_W-2:0]   key_ext, body;
   logic [NUM_PTRN-1:0] match, mask_next;
   logic [IDX_W-1:0]    sel_idx;

   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s,
                                                   input logic [LFSR_W-1:0] t);
      return {s[LFSR_W-2:0], ^(s & t)};
   endfunction

   // Table index 0 sits in the most significant slot of the concatenation.
   function automatic logic [LFSR_W-1:0] ptrn_at(input int i);
      return PTRN_TABLE[(NUM_PTRN-1-i)*LFSR_W +: LFSR_W];
   endfunction

   // Input and output streams are valid/ready: a beat transfers on the rising edge where
   // valid and ready are both high; once raised, Out_valid and Out_data hold until taken.
   always_comb begin
      active   = (state_q == S_SEED) || (state_q == S_TRAIN) || (state_q == S_RUN);
      out_free = !out_valid_q || Out_ready;
      In_ready = active && out_free && (cnt_q < len_q);
      accept   = In_valid && In_ready;
      obs      = In_data[LFSR_W-1:0] ^ PAD_CHAR[LFSR_W-1:0];
      key_ext  = '0;
      key_ext[LFSR_W-1:0] = lfsr_q;
      body     = In_data[DATA_W-2:0] ^ key_ext;
      match    = '0;
      for (int i = 0; i < NUM_PTRN; i++) begin
         match[i] = (lfsr_step(lfsr_q, ptrn_at(i)) == obs);
      end
      mask_next = mask_q & match;
      sel_idx   = '0;
      for (int i = NUM_PTRN-1; i >= 0; i--) begin
         if (mask_next[i]) sel_idx = IDX_W'(i);
      end
      sel_taps   = ptrn_at(int'(sel_idx));
      train_last = (cnt_q == LEN_W'(TRAIN_LEN-1));
   end

   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      len_d        = len_q;
      cnt_d        = cnt_q;
      lfsr_d       = lfsr_q;
      taps_d       = taps_q;
      mask_d       = mask_q;
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      ack_d        = 1'b0;
      parity_err_d = parity_err_q;
      ptrn_found_d = ptrn_found_q;
      ptrn_idx_d   = ptrn_idx_q;
      key_err_d    = key_err_q;

      if (out_valid_q && Out_ready) out_valid_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (Start) begin
               mode_d       = Mode;
               len_d        = Len;
               cnt_d        = '0;
               lfsr_d       = Seed_in;
               taps_d       = Taps_in;
               mask_d       = '0;
               parity_err_d = 1'b0;
               ptrn_found_d = 1'b0;
               ptrn_idx_d   = '0;
               key_err_d    = 1'b0;
               if (Len == '0) begin
                  state_d = S_DONE;
                  ack_d   = 1'b1;
               end else if (Mode) begin
                  state_d = S_SEED;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_SEED, S_TRAIN, S_RUN: begin
            if (accept) begin
               cnt_d       = cnt_q + LEN_W'(1);
               out_valid_d = 1'b1;
               if (mode_q) parity_err_d = parity_err_q | (^In_data);
               if (state_q == S_SEED) begin
                  lfsr_d     = obs;
                  mask_d     = '1;
                  out_data_d = PAD_CHAR;
                  state_d    = S_TRAIN;
               end else if (state_q == S_TRAIN) begin
                  // During training lfsr_q holds the previous observed keystream value.
                  lfsr_d     = obs;
                  mask_d     = mask_next;
                  out_data_d = PAD_CHAR;
                  if (train_last) begin
                     ptrn_found_d = |mask_next;
                     key_err_d    = ~|mask_next;
                     ptrn_idx_d   = sel_idx;
                     taps_d       = sel_taps;
                     lfsr_d       = lfsr_step(obs, sel_taps);
                     state_d      = S_RUN;
                  end
               end else begin
                  out_data_d = mode_q ? {1'b0, body} : {^body, body};
                  lfsr_d     = lfsr_step(lfsr_q, taps_q);
               end
            end else if ((cnt_q == len_q) && out_free) begin
               state_d = S_DONE;
               ack_d   = 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q      <= S_IDLE;
         mode_q       <= 1'b0;
         len_q        <= '0;
         cnt_q        <= '0;
         lfsr_q       <= '0;
         taps_q       <= '0;
         mask_q       <= '0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         ack_q        <= 1'b0;
         parity_err_q <= 1'b0;
         ptrn_found_q <= 1'b0;
         ptrn_idx_q   <= '0;
         key_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         len_q        <= len_d;
         cnt_q        <= cnt_d;
         lfsr_q       <= lfsr_d;
         taps_q       <= taps_d;
         mask_q       <= mask_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         busy_q       <= busy_d;
         ack_q        <= ack_d;
         parity_err_q <= parity_err_d;
         ptrn_found_q <= ptrn_found_d;
         ptrn_idx_q   <= ptrn_idx_d;
         key_err_q    <= key_err_d;
      end
   end

   assign Out_data   = out_data_q;
   assign Out_valid  = out_valid_q;
   assign Busy       = busy_q;
   assign Ack        = ack_q;
   assign Parity_err = parity_err_q;
   assign Ptrn_found = ptrn_found_q;
   assign Ptrn_idx   = ptrn_idx_q;
   assign Key_err    = key_err_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_lfsr_crypt_engine.sv
// Directed bench for lfsr_crypt_engine: encrypt, key recovery, parity, backpressure,
// mid-run reset and short/degenerate runs, checked through an expected-output queue.
module tb_lfsr_crypt_engine;

   localparam logic [7:0] PAD = 8'h20;

   logic       clk;
   logic       Reset, Start, Mode;
   logic [6:0] Taps_in, Seed_in, Len;
   logic [7:0] In_data;
   logic       In_valid, In_ready;
   logic [7:0] Out_data;
   logic       Out_valid, Out_ready;
   logic       Busy, Ack, Parity_err, Ptrn_found, Key_err;
   logic [3:0] Ptrn_idx;
   logic [2:0] dbg_state;

   int         checks = 0;
   int         failures = 0;
   int         ack_cnt = 0;
   bit         bp_mode = 1'b0;
   logic [7:0] exp_q[$];
   logic [7:0] stim[128];
   logic [7:0] plain[128];
   logic       held_v = 1'b0;
   logic [7:0] held_d;
   logic [7:0] mon_exp;

   lfsr_crypt_engine dut (
      .Clk(clk), .Reset(Reset), .Start(Start), .Mode(Mode),
      .Taps_in(Taps_in), .Seed_in(Seed_in), .Len(Len),
      .In_data(In_data), .In_valid(In_valid), .In_ready(In_ready),
      .Out_data(Out_data), .Out_valid(Out_valid), .Out_ready(Out_ready),
      .Busy(Busy), .Ack(Ack), .Parity_err(Parity_err), .Ptrn_found(Ptrn_found),
      .Ptrn_idx(Ptrn_idx), .Key_err(Key_err), .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [6:0] step7(input logic [6:0] s, input logic [6:0] t);
      return {s[5:0], ^(s & t)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // output sink: always ready, or toggling every cycle under backpressure
   initial begin
      Out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         Out_ready = bp_mode ? !Out_ready : 1'b1;
      end
   end

   // scoreboard / monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (Ack) ack_cnt++;
      if (held_v) begin
         chk("stall_valid_hold", 32'(Out_valid), 32'(1));
         chk("stall_data_hold", 32'(Out_data), 32'(held_d));
      end
      if (Out_valid && !Out_ready) begin
         chk("stall_in_ready", 32'(In_ready), 32'(0));
         held_v = 1'b1;
         held_d = Out_data;
      end else begin
         held_v = 1'b0;
      end
      if (Out_valid && Out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL out_unexpected observed=%0h expected=none", Out_data);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("out_data", 32'(Out_data), 32'(mon_exp));
         end
      end
   end

   // driver tasks
   task automatic start_run(input logic m, input logic [6:0] t, input logic [6:0] s,
                            input logic [6:0] l);
      Mode = m; Taps_in = t; Seed_in = s; Len = l; Start = 1'b1;
      @(posedge clk);
      #1;
      Start = 1'b0;
   endtask

   task automatic drive_range(input int lo, input int hi);
      for (int k = lo; k <= hi; k++) begin
         bit got;
         got = 1'b0;
         In_data = stim[k];
         In_valid = 1'b1;
         for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (In_ready) got = 1'b1;
         end
         @(posedge clk);
         #1;
         if (!got) begin
            checks++;
            failures++;
            $error("FAIL accept_timeout observed=no_accept expected=accept byte=%0d", k);
         end
      end
      In_valid = 1'b0;
   endtask

   task automatic wait_ack(input string t, input int base);
      bit got;
      got = 1'b0;
      for (int c = 0; c < 400 && !got; c++) begin
         @(posedge clk);
         #1;
         if (ack_cnt != base) got = 1'b1;
      end
      repeat (3) @(posedge clk);
      #1;
      chk({t, "_ack_once"}, 32'(ack_cnt - base), 32'(1));
      chk({t, "_busy_idle"}, 32'(Busy), 32'(0));
      chk({t, "_drain"}, 32'(exp_q.size()), 32'(0));
   endtask

   task automatic check_reset_values(input string t);
      chk({t, "_out_valid"}, 32'(Out_valid), 32'(0));
      chk({t, "_out_data"}, 32'(Out_data), 32'(0));
      chk({t, "_in_ready"}, 32'(In_ready), 32'(0));
      chk({t, "_busy"}, 32'(Busy), 32'(0));
      chk({t, "_ack"}, 32'(Ack), 32'(0));
      chk({t, "_parity_err"}, 32'(Parity_err), 32'(0));
      chk({t, "_ptrn_found"}, 32'(Ptrn_found), 32'(0));
      chk({t, "_ptrn_idx"}, 32'(Ptrn_idx), 32'(0));
      chk({t, "_key_err"}, 32'(Key_err), 32'(0));
      chk({t, "_state"}, 32'(dbg_state), 32'(0));
   endtask

   task automatic build_cipher(input logic [6:0] taps, input logic [6:0] seed, input int n);
      logic [6:0] st, c7;
      st = seed;
      for (int k = 0; k < n; k++) begin
         c7 = plain[k][6:0] ^ st;
         stim[k] = {^c7, c7};
         st = step7(st, taps);
      end
   endtask

   task automatic enc_short(input string t);
      int base;
      base = ack_cnt;
      stim[0] = 8'h20;
      stim[1] = 8'h20;
      exp_q.push_back(8'h21);
      exp_q.push_back(8'h22);
      start_run(1'b0, 7'h7E, 7'h01, 7'd2);
      chk({t, "_busy_run"}, 32'(Busy), 32'(1));
      drive_range(0, 1);
      wait_ack(t, base);
   endtask

   initial begin
      logic [6:0] st, c7;
      logic       par;
      int         base;

      Reset = 1'b1; Start = 1'b0; Mode = 1'b0; Taps_in = '0; Seed_in = '0; Len = '0;
      In_data = '0; In_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("por");
      Reset = 1'b0;
      @(posedge clk);
      #1;

      // short encrypt with known keystream
      enc_short("enc2");

      // decrypt key recovery: 12 pad bytes then printable text
      for (int k = 0; k < 64; k++) plain[k] = (k < 12) ? PAD : 8'($urandom_range(33, 126));
      build_cipher(7'h7E, 7'h01, 64);
      for (int k = 0; k < 64; k++) exp_q.push_back(plain[k]);
      base = ack_cnt;
      start_run(1'b1, 7'h00, 7'h00, 7'd64);
      drive_range(0, 63);
      wait_ack("dec64", base);
      chk("dec64_found", 32'(Ptrn_found), 32'(1));
      chk("dec64_idx", 32'(Ptrn_idx), 32'(7));
      chk("dec64_key_err", 32'(Key_err), 32'(0));
      chk("dec64_parity", 32'(Parity_err), 32'(0));

      // same stream with a parity fault on byte 20
      stim[20] = stim[20] ^ 8'h80;
      for (int k = 0; k < 64; k++) exp_q.push_back(plain[k]);
      base = ack_cnt;
      start_run(1'b1, 7'h00, 7'h00, 7'd64);
      drive_range(0, 19);
      chk("par_before", 32'(Parity_err), 32'(0));
      drive_range(20, 20);
      chk("par_at_20", 32'(Parity_err), 32'(1));
      drive_range(21, 63);
      wait_ack("par", base);
      chk("par_sticky", 32'(Parity_err), 32'(1));
      chk("par_found", 32'(Ptrn_found), 32'(1));

      // encrypt under toggling backpressure
      bp_mode = 1'b1;
      st = 7'h35;
      for (int k = 0; k < 20; k++) begin
         stim[k] = 8'($urandom_range(0, 255));
         c7 = stim[k][6:0] ^ st;
         exp_q.push_back({^c7, c7});
         st = step7(st, 7'h5C);
      end
      base = ack_cnt;
      start_run(1'b0, 7'h5C, 7'h35, 7'd20);
      chk("bp_parity_cleared", 32'(Parity_err), 32'(0));
      chk("bp_found_cleared", 32'(Ptrn_found), 32'(0));
      chk("bp_idx_cleared", 32'(Ptrn_idx), 32'(0));
      drive_range(0, 19);
      wait_ack("bp", base);
      bp_mode = 1'b0;
      @(posedge clk);
      #1;

      // reset in the middle of a decrypt, Start held with it
      build_cipher(7'h7E, 7'h01, 64);
      for (int k = 0; k < 5; k++) exp_q.push_back(plain[k]);
      start_run(1'b1, 7'h00, 7'h00, 7'd64);
      drive_range(0, 4);
      chk("mid_busy", 32'(Busy), 32'(1));
      Reset = 1'b1; Start = 1'b1; Mode = 1'b0; Len = 7'd2;
      @(posedge clk);
      #1;
      check_reset_values("mid_rst");
      Reset = 1'b0; Start = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rst_start_ignored", 32'(Busy), 32'(0));
      exp_q.delete();
      enc_short("after_rst");

      // zero-length run
      base = ack_cnt;
      start_run(1'b0, 7'h7E, 7'h01, 7'd0);
      chk("len0_busy", 32'(Busy), 32'(1));
      wait_ack("len0", base);

      // decrypt shorter than training
      build_cipher(7'h7E, 7'h01, 4);
      for (int k = 0; k < 4; k++) exp_q.push_back(PAD);
      base = ack_cnt;
      start_run(1'b1, 7'h00, 7'h00, 7'd4);
      drive_range(0, 3);
      wait_ack("len4", base);
      chk("len4_found", 32'(Ptrn_found), 32'(0));
      chk("len4_key_err", 32'(Key_err), 32'(0));

      // stream no candidate can produce: zero state followed by a one
      stim[0] = 8'h20;
      stim[1] = 8'h21;
      for (int k = 2; k < 16; k++) stim[k] = 8'($urandom_range(0, 255));
      par = 1'b0;
      for (int k = 0; k < 16; k++) par = par | (^stim[k]);
      for (int k = 0; k < 8; k++) exp_q.push_back(PAD);
      st = step7(stim[7][6:0] ^ 7'h20, 7'h60);
      for (int k = 8; k < 16; k++) begin
         exp_q.push_back({1'b0, stim[k][6:0] ^ st});
         st = step7(st, 7'h60);
      end
      base = ack_cnt;
      start_run(1'b1, 7'h00, 7'h00, 7'd16);
      drive_range(0, 15);
      wait_ack("keyerr", base);
      chk("keyerr_flag", 32'(Key_err), 32'(1));
      chk("keyerr_found", 32'(Ptrn_found), 32'(0));
      chk("keyerr_idx", 32'(Ptrn_idx), 32'(0));
      chk("keyerr_parity", 32'(Parity_err), 32'(par));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
